// File: rtl/imem_boot_loader_pkg.sv
// mips_boot_pkg: shared FSM state type and image-format constants for the boot loader.
package mips_boot_pkg;
  typedef enum logic [2:0] {ADDR, COUNT, DATA, CHECK, RUN, ERROR} state_t;
  localparam int HDR_BYTES = 8;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] ALIGN_MASK = 32'h3;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in, instruction-memory write port out.
interface imem_boot_loader_if;
  logic [7:0] s_data;
  logic s_valid, s_ready, imem_we;
  logic [31:0] imem_addr, imem_wdata;
  modport master (output s_data, s_valid, input s_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input s_data, s_valid, output s_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_boot_loader_byte_word_packer.sv
// byte_word_packer: big-endian byte-to-word assembler; word/word_done are valid in the 4th byte's accept cycle.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done,
  output logic [1:0]  idx
);
  logic [23:0] sh;
  assign word = {sh, din};
  assign word_done = en && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sh  <= '0;
      idx <= '0;
    end else if (en) begin
      sh  <= word[23:0];
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: parses an address/count/payload/checksum byte image, writes imem, then releases the core.
import mips_boot_pkg::*;
module imem_boot_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_boot_loader_if.slave   bus,
  output logic                core_run,
  output logic [31:0]         pc_value,
  output logic                busy,
  output logic                err
);
  localparam int CW = $clog2(MAX_WORDS + 1);
  state_t state;
  logic [31:0] load_addr, ptr, word;
  logic [CW-1:0] cnt;
  logic [7:0] xsum;
  logic [1:0] idx;
  logic take, word_done;
  assign bus.s_ready = state inside {ADDR, COUNT, DATA, CHECK};
  assign take = bus.s_valid && bus.s_ready;
  assign busy = (state == ADDR && idx != 2'd0) || state inside {COUNT, DATA, CHECK};
  assign core_run = state == RUN;
  assign err = state == ERROR;
  assign pc_value = core_run ? load_addr : '0;
  byte_word_packer u_pack (
    .clk(clk), .rst_n(rst_n), .en(take), .din(bus.s_data),
    .word(word), .word_done(word_done), .idx(idx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= ADDR;
      load_addr      <= '0;
      ptr            <= '0;
      cnt            <= '0;
      xsum           <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (take)
        case (state)
          ADDR: if (word_done) begin
            load_addr <= word;
            state     <= (word & ALIGN_MASK) != '0 ? ERROR : COUNT;
          end
          COUNT: if (word_done) begin
            ptr   <= load_addr;
            cnt   <= word[CW-1:0];
            state <= word > 32'(MAX_WORDS) ? ERROR : word == '0 ? CHECK : DATA;
          end
          DATA: begin
            xsum <= xsum ^ bus.s_data;
            if (word_done) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= ptr;
              bus.imem_wdata <= word;
              ptr            <= ptr + 32'(WORD_BYTES);
              cnt            <= cnt - CW'(1);
              state          <= cnt == CW'(1) ? CHECK : DATA;
            end
          end
          CHECK: state <= bus.s_data == xsum ? RUN : ERROR;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed image loads with a write scoreboard and immediate-assertion checks.
module tb_imem_boot_loader;
  logic clk = 1'b0, rst_n = 1'b0;
  logic core_run, busy, err;
  logic [31:0] pc_value;
  int checks = 0, passes = 0, cyc = 0;
  bit gaps = 0;
  logic [63:0] sb[$];
  int wr_cyc[$];
  localparam logic [31:0] W0 = 32'h8C130000, W1 = 32'h02549820;

  imem_boot_loader_if bus ();
  imem_boot_loader #(.MAX_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .core_run(core_run), .pc_value(pc_value), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst_n && bus.imem_we) begin
      logic [63:0] exp;
      exp = sb.size() > 0 ? sb.pop_front() : 'x;
      wr_cyc.push_back(cyc);
      checks++;
      assert ({bus.imem_addr, bus.imem_wdata} === exp) passes++;
      else $error("FAIL imem_write: got %h expected %h", {bus.imem_addr, bus.imem_wdata}, exp);
    end

  initial begin
    #300000;
    $error("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] xw(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic send(input logic [7:0] b);
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        @(negedge clk);
      end
    bus.s_valid = 1'b1;
    bus.s_data = b;
    @(negedge clk);
  endtask

  task automatic send_w(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic send_image(input logic [31:0] a, input int n, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [7:0] flip);
    logic [31:0] w[2];
    logic [7:0] x = 8'h00;
    w[0] = w0;
    w[1] = w1;
    send_w(a);
    send_w(32'(n));
    for (int i = 0; i < n; i++) begin
      sb.push_back({a + 32'(4 * i), w[i]});
      x ^= xw(w[i]);
      send_w(w[i]);
    end
    send(x ^ flip);
  endtask

  task automatic idle(input int k);
    bus.s_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, 64'({bus.s_ready, bus.imem_we, core_run, busy, err}), 64'(5'b10000));
    chk({tag, "_imem"}, {bus.imem_addr, bus.imem_wdata}, 64'h0);
    chk({tag, "_pc"}, 64'(pc_value), 64'h0);
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    wr_cyc.delete();
  endtask

  task automatic check_run(input string tag, input logic [31:0] pc);
    chk({tag, "_run"}, 64'({core_run, err, busy, bus.s_ready}), 64'(4'b1000));
    chk({tag, "_pc"}, 64'(pc_value), 64'(pc));
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(negedge clk);

    send_image(32'h1F4, 2, W0, W1, 8'h00);
    check_run("full", 32'd500);
    idle(4);
    chk("full_pending", 64'(sb.size()), 64'd0);
    chk("full_nwr", 64'(wr_cyc.size()), 64'd2);
    chk("full_spacing", 64'(wr_cyc.size() == 2 ? wr_cyc[1] - wr_cyc[0] : 0), 64'd4);

    do_reset();
    gaps = 1;
    send_image(32'h1F4, 2, W0, W1, 8'h00);
    gaps = 0;
    check_run("gaps", 32'd500);
    idle(4);
    chk("gaps_pending", 64'(sb.size()), 64'd0);
    chk("gaps_nwr", 64'(wr_cyc.size()), 64'd2);

    do_reset();
    chk("idle_busy", 64'(busy), 64'd0);
    send(8'h00);
    chk("busy_first_byte", 64'(busy), 64'd1);
    send(8'h00);
    send(8'h01);
    chk("misalign_pre", 64'(err), 64'd0);
    send(8'hF6);
    chk("misalign_err", 64'({err, bus.s_ready, core_run, busy}), 64'(4'b1000));
    repeat (6) send(8'h55);
    idle(2);
    chk("misalign_sticky", 64'(err), 64'd1);
    chk("misalign_nwr", 64'(wr_cyc.size()), 64'd0);

    do_reset();
    send_image(32'h40, 0, W0, W1, 8'h00);
    check_run("n0_ok", 32'h40);
    idle(2);
    chk("n0_nwr", 64'(wr_cyc.size()), 64'd0);
    do_reset();
    send_image(32'h40, 0, W0, W1, 8'h01);
    chk("n0_bad", 64'({err, core_run, bus.s_ready}), 64'(3'b100));

    do_reset();
    send_w(32'h1000);
    send(8'h00);
    send(8'h00);
    send(8'h04);
    chk("nmax1_pre", 64'({err, busy}), 64'(2'b01));
    send(8'h01);
    chk("nmax1_err", 64'({err, bus.s_ready}), 64'(2'b10));
    do_reset();
    send_w(32'h1000);
    send_w(32'd1024);
    chk("nmax_ok", 64'({err, busy, bus.s_ready}), 64'(3'b011));

    do_reset();
    send_image(32'h1F4, 2, W0, W1, 8'hFF);
    chk("badsum", 64'({err, core_run, bus.s_ready}), 64'(3'b100));
    idle(3);
    chk("badsum_pending", 64'(sb.size()), 64'd0);
    chk("badsum_nwr", 64'(wr_cyc.size()), 64'd2);

    do_reset();
    send_w(32'h200);
    send_w(32'd2);
    sb.push_back({32'h200, W0});
    send_w(W0);
    chk("mid_we", 64'(bus.imem_we), 64'd1);
    do_reset();
    chk("mid_busy", 64'(busy), 64'd0);
    send_image(32'h300, 2, W1, W0, 8'h00);
    check_run("reload", 32'h300);
    idle(3);
    chk("reload_pending", 64'(sb.size()), 64'd0);
    chk("reload_nwr", 64'(wr_cyc.size()), 64'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
